// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal shift/rotate register with a self-timed MSB-first serialise burst
module univ_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] par_in,
    input  logic             sin,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             busy,
    output logic             done
);
    localparam int CNTW = $clog2(WIDTH);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [WIDTH-1:0]  shl, op;
    assign shl = {q_q[WIDTH-2:0], sin};
    assign op  = mode == 3'b001 ? par_in :
                 mode == 3'b010 ? shl :
                 mode == 3'b011 ? {sin, q_q[WIDTH-1:1]} :
                 mode == 3'b100 ? {q_q[WIDTH-2:0], q_q[WIDTH-1]} :
                 mode == 3'b101 ? {q_q[0], q_q[WIDTH-1:1]} :
                 mode == 3'b110 ? '0 : q_q;
    assign q        = q_q;
    assign sout_msb = q_q[WIDTH-1];
    assign sout_lsb = q_q[0];
    assign busy     = state_q == SHIFT;
    assign done     = busy && cnt_q == '0;
    // next state: a running burst owns the register; when idle, start beats mode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        if (state_q == SHIFT) begin
            if (cnt_q != '0) begin
                q_d   = shl;
                cnt_d = cnt_q - 1'b1;
            end else begin
                state_d = IDLE;
            end
        end else if (start) begin
            q_d     = par_in;
            cnt_d   = CNTW'(WIDTH - 1);
            state_d = SHIFT;
        end else begin
            q_d = op;
        end
    end
    // state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
        end
    end
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed checks of the universal register and serialise burst at WIDTH 4 and 8
module tb_univ_shift_reg;
    logic       clk, rstn;
    logic [2:0] mode, mode8;
    logic [3:0] par_in, q;
    logic [7:0] par8, q8;
    logic       sin, start, sout_msb, sout_lsb, busy, done;
    logic       sin8, start8, msb8, lsb8, busy8, done8;
    logic [3:0] exp4;
    logic [7:0] exp8;
    int         errors = 0;
    int         checks = 0;

    univ_shift_reg #(.WIDTH(4)) dut (
        .clk(clk), .rstn(rstn), .mode(mode), .par_in(par_in), .sin(sin), .start(start),
        .q(q), .sout_msb(sout_msb), .sout_lsb(sout_lsb), .busy(busy), .done(done)
    );

    univ_shift_reg #(.WIDTH(8)) dut8 (
        .clk(clk), .rstn(rstn), .mode(mode8), .par_in(par8), .sin(sin8), .start(start8),
        .q(q8), .sout_msb(msb8), .sout_lsb(lsb8), .busy(busy8), .done(done8)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load4(input logic [3:0] v);
        mode = 3'b001; par_in = v; tick();
    endtask

    initial begin
        rstn = 0; mode = 0; par_in = 0; sin = 0; start = 0;
        mode8 = 0; par8 = 0; sin8 = 0; start8 = 0;
        tick(); tick();
        rstn = 1;
        chk("idle_q", q, 0);
        chk("idle_busy", busy, 0);
        // reset over a busy register full of ones
        par_in = 4'b1111; start = 1; tick();
        start = 0; sin = 1;
        chk("pre_q", q, 4'b1111);
        chk("pre_busy", busy, 1);
        rstn = 0; tick();
        chk("rst_q", q, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rstn = 1;
        // load / hold / reserved / clear
        load4(4'b1011);
        chk("load", q, 4'b1011);
        mode = 3'b000; tick(); tick(); tick();
        chk("hold3", q, 4'b1011);
        mode = 3'b111; tick();
        chk("mode7", q, 4'b1011);
        mode = 3'b110; tick();
        chk("clr", q, 0);
        // shifts and rotates from a fresh 1011
        load4(4'b1011); mode = 3'b010; sin = 0; tick();
        chk("shl", q, 4'b0110);
        load4(4'b1011); mode = 3'b011; sin = 1; tick();
        chk("shr", q, 4'b1101);
        chk("shr_lsb", sout_lsb, 1);
        load4(4'b1011); mode = 3'b100; tick();
        chk("rol", q, 4'b0111);
        load4(4'b1011); mode = 3'b101; tick();
        chk("ror", q, 4'b1101);
        chk("ror_msb", sout_msb, 1);
        // basic burst
        mode = 3'b000; par_in = 4'b1011; sin = 0; start = 1; tick();
        start = 0; exp4 = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            chk("b_msb", sout_msb, exp4[3-i]);
            chk("b_busy", busy, 1);
            chk("b_done", done, (i == 3) ? 1 : 0);
            tick();
        end
        chk("b_end_busy", busy, 0);
        chk("b_end_done", done, 0);
        chk("b_end_q", q, 4'b1000);
        // WIDTH=8 burst
        par8 = 8'hA5; sin8 = 0; start8 = 1; tick();
        start8 = 0; exp8 = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            chk("b8_msb", msb8, exp8[7-i]);
            chk("b8_busy", busy8, 1);
            chk("b8_done", done8, (i == 7) ? 1 : 0);
            tick();
        end
        chk("b8_end_busy", busy8, 0);
        chk("b8_end_q", q8, 8'h80);
        // mid-burst start/mode and start in the done cycle are ignored
        par_in = 4'b1011; sin = 0; start = 1; tick();
        mode = 3'b001; par_in = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            chk("m_msb", sout_msb, exp4[3-i]);
            chk("m_done", done, (i == 3) ? 1 : 0);
            tick();
        end
        chk("m_end_busy", busy, 0);
        chk("m_end_q", q, 4'b1000);
        par_in = 4'b0110; tick();
        chk("restart_busy", busy, 1);
        chk("restart_q", q, 4'b0110);
        start = 0; mode = 3'b000;
        tick(); tick(); tick(); tick();
        chk("restart_end", busy, 0);
        // reset in the second burst cycle
        par_in = 4'b1011; start = 1; tick();
        start = 0; tick();
        rstn = 0; tick();
        chk("mid_rst_q", q, 0);
        chk("mid_rst_busy", busy, 0);
        rstn = 1;
        for (int i = 0; i < 4; i++) begin
            chk("mid_rst_nodone", done, 0);
            tick();
        end
        // start while in reset
        start = 1; rstn = 0; tick();
        chk("rst_start_busy", busy, 0);
        chk("rst_start_q", q, 0);
        rstn = 1; start = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
